// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALU operation
// codes, FSM state encoding and the bundle of datapath control strobes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R_TYPE = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_LUI   = 3'b011;
    localparam logic [2:0] ALU_ADDI  = 3'b100;
    localparam logic [2:0] ALU_ORI   = 3'b101;
    localparam logic [2:0] ALU_ANDI  = 3'b110;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_eq;
        logic       pc_write_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
    } ctrl_t;

    // Wait counter must hold 0..timeout; a zero timeout still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath /
// memory side (slave).
interface multicycle_control_if;
    logic [5:0] OP;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCondEQ;
    logic       PCWriteCondNE;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic [1:0] PCSource;
    logic [2:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic       RegDst;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_error;
    logic [3:0] state_o;

    modport master (
        input  OP, mem_ready,
        output PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite,
               MemtoReg, IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite,
               RegDst, instr_done, illegal_op, bus_error, state_o
    );

    modport slave (
        output OP, mem_ready,
        input  PCWrite, PCWriteCondEQ, PCWriteCondNE, IorD, MemRead, MemWrite,
               MemtoReg, IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite,
               RegDst, instr_done, illegal_op, bus_error, state_o
    );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts unready cycles of a pending memory access and flags the cycle on which
// the access must be abandoned.
module mem_wait_timer
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    input  logic clear,
    output logic expired
);
    localparam int unsigned W           = cnt_width(MEM_TIMEOUT);
    localparam bit          HAS_TIMEOUT = (MEM_TIMEOUT != 0);
    localparam logic [W-1:0] CNT_MAX    = '1;
    localparam logic [W-1:0] CNT_LAST   = W'(HAS_TIMEOUT ? MEM_TIMEOUT - 1 : 0);

    logic [W-1:0] wait_cnt_q;
    logic [W-1:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear) begin
            wait_cnt_d = '0;
        end else if (active && !ready && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A ready response in the last tolerated cycle still completes normally.
    assign expired = HAS_TIMEOUT && active && !ready && (wait_cnt_q == CNT_LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: Moore-decoded datapath strobes, ready-handshaked
// memory states with timeout, sticky illegal-opcode and bus-error halts.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_if.master   bus
);
    state_t state_q, state_d;
    logic   illegal_op_q, illegal_op_d;
    logic   bus_error_q, bus_error_d;
    ctrl_t  ctrl, ctrl_o;
    logic   mem_active;
    logic   expired;

    assign mem_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .active  (mem_active),
        .ready   (bus.mem_ready),
        .clear   (state_d != state_q),
        .expired (expired)
    );

    always_comb begin
        state_d      = state_q;
        illegal_op_d = illegal_op_q;
        bus_error_d  = bus_error_q;
        ctrl         = '0;
        unique case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALU_ADD;
                if (bus.mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_d       = S_DECODE;
                end else if (expired) begin
                    state_d     = S_HALT;
                    bus_error_d = 1'b1;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_op    = ALU_ADD;
                case (bus.OP)
                    OP_R_TYPE:                          state_d = S_R_EXEC;
                    OP_LW, OP_SW:                       state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                     state_d = S_BRANCH;
                    OP_J:                               state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI:   state_d = S_I_EXEC;
                    default: begin
                        state_d      = S_HALT;
                        illegal_op_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALU_ADD;
                state_d        = (bus.OP == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (expired) begin
                    state_d     = S_HALT;
                    bus_error_d = 1'b1;
                end
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                if (bus.mem_ready) begin
                    ctrl.instr_done = 1'b1;
                    state_d         = S_FETCH;
                end else if (expired) begin
                    state_d     = S_HALT;
                    bus_error_d = 1'b1;
                end
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_RTYPE;
                state_d        = S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_op      = ALU_SUB;
                ctrl.pc_source   = 2'b01;
                ctrl.pc_write_eq = (bus.OP == OP_BEQ);
                ctrl.pc_write_ne = (bus.OP == OP_BNE);
                ctrl.instr_done  = 1'b1;
                state_d          = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = 2'b10;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_I_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                case (bus.OP)
                    OP_ADDI: ctrl.alu_op = ALU_ADDI;
                    OP_ANDI: ctrl.alu_op = ALU_ANDI;
                    OP_ORI:  ctrl.alu_op = ALU_ORI;
                    default: ctrl.alu_op = ALU_LUI;
                endcase
                state_d = S_I_WB;
            end
            S_I_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            illegal_op_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
            bus_error_q  <= bus_error_d;
        end
    end

    // Strobes are silenced while reset is held so an interrupted access cannot complete.
    assign ctrl_o = reset ? '0 : ctrl;

    assign bus.PCWrite       = ctrl_o.pc_write;
    assign bus.PCWriteCondEQ = ctrl_o.pc_write_eq;
    assign bus.PCWriteCondNE = ctrl_o.pc_write_ne;
    assign bus.IorD          = ctrl_o.iord;
    assign bus.MemRead       = ctrl_o.mem_read;
    assign bus.MemWrite      = ctrl_o.mem_write;
    assign bus.MemtoReg      = ctrl_o.mem_to_reg;
    assign bus.IRWrite       = ctrl_o.ir_write;
    assign bus.PCSource      = ctrl_o.pc_source;
    assign bus.ALUOp         = ctrl_o.alu_op;
    assign bus.ALUSrcA       = ctrl_o.alu_src_a;
    assign bus.ALUSrcB       = ctrl_o.alu_src_b;
    assign bus.RegWrite      = ctrl_o.reg_write;
    assign bus.RegDst        = ctrl_o.reg_dst;
    assign bus.instr_done    = ctrl_o.instr_done;
    assign bus.illegal_op    = illegal_op_q;
    assign bus.bus_error     = bus_error_q;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: two instances (timeout 15 and 4) share
// the same opcode / ready stimulus and are checked cycle by cycle.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    int         checks = 0;
    int         failures = 0;
    int         ir_cnt;
    int         pc_cnt;

    always #5 clk = ~clk;

    multicycle_control_if if15 ();
    multicycle_control_if if4 ();

    assign if15.OP = op;
    assign if15.mem_ready = rdy;
    assign if4.OP = op;
    assign if4.mem_ready = rdy;

    multicycle_control #(.MEM_TIMEOUT(15)) dut15 (.clk(clk), .reset(rst), .bus(if15));
    multicycle_control #(.MEM_TIMEOUT(4))  dut4  (.clk(clk), .reset(rst), .bus(if4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, then apply the inputs for the new cycle and let them settle.
    task automatic cyc(input logic r, input logic [5:0] o, input logic m);
        @(posedge clk);
        #1;
        rst = r;
        op  = o;
        rdy = m;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        op  = 6'h00;
        rdy = 1'b1;
        #2;
        check("rst_memread_gated", if15.MemRead, 1'b0);
        check("rst_irwrite_gated", if15.IRWrite, 1'b0);
        cyc(1'b1, 6'h00, 1'b1);
        check("rst_state", if15.state_o, 4'd0);
        check("rst_flags", {if15.illegal_op, if15.bus_error}, 2'b00);

        // lw: FETCH DECODE MEM_ADDR MEM_RD MEM_WB
        cyc(1'b0, 6'h23, 1'b1);
        check("lw_c1_state", if15.state_o, 4'd0);
        check("lw_c1_fetch", {if15.MemRead, if15.IRWrite, if15.PCWrite, if15.IorD, if15.ALUSrcB}, 6'b111001);
        cyc(1'b0, 6'h23, 1'b1);
        check("lw_c2_state", if15.state_o, 4'd1);
        check("lw_c2_srcb", if15.ALUSrcB, 2'b11);
        cyc(1'b0, 6'h23, 1'b1);
        check("lw_c3_state", if15.state_o, 4'd2);
        check("lw_c3_alu", {if15.ALUSrcA, if15.ALUSrcB, if15.ALUOp}, 6'b110000);
        check("lw_c3_regwrite", if15.RegWrite, 1'b0);
        cyc(1'b0, 6'h23, 1'b1);
        check("lw_c4_state", if15.state_o, 4'd3);
        check("lw_c4_mem", {if15.MemRead, if15.IorD, if15.MemtoReg, if15.instr_done}, 4'b1100);
        cyc(1'b0, 6'h23, 1'b1);
        check("lw_c5_state", if15.state_o, 4'd4);
        check("lw_c5_wb", {if15.RegWrite, if15.MemtoReg, if15.RegDst, if15.instr_done}, 4'b1101);
        $display("txn lw complete");

        // Fetch with three unready cycles, then beq
        ir_cnt = 0;
        pc_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 6'h04, (i == 3));
            check("fw_state", if15.state_o, 4'd0);
            check("fw_memread", if15.MemRead, 1'b1);
            check("fw_done", if15.instr_done, 1'b0);
            ir_cnt += int'(if15.IRWrite);
            pc_cnt += int'(if15.PCWrite);
        end
        check("fw_irwrite_last", if15.IRWrite, 1'b1);
        check("fw_irwrite_count", ir_cnt, 1);
        check("fw_pcwrite_count", pc_cnt, 1);
        cyc(1'b0, 6'h04, 1'b1);
        check("beq_c2_state", if15.state_o, 4'd1);
        check("fw_no_err15", if15.bus_error, 1'b0);
        check("fw_no_err4", {if4.bus_error, if4.state_o}, 5'h01);
        cyc(1'b0, 6'h04, 1'b1);
        check("beq_c3_state", if15.state_o, 4'd8);
        check("beq_c3_ctrl", {if15.ALUOp, if15.PCSource, if15.PCWriteCondEQ, if15.PCWriteCondNE, if15.instr_done}, 8'b00101101);
        $display("txn beq complete");

        // bne
        cyc(1'b0, 6'h05, 1'b1);
        check("bne_c1_state", if15.state_o, 4'd0);
        cyc(1'b0, 6'h05, 1'b1);
        check("bne_c2_state", if15.state_o, 4'd1);
        cyc(1'b0, 6'h05, 1'b1);
        check("bne_c3_state", if15.state_o, 4'd8);
        check("bne_c3_ctrl", {if15.ALUOp, if15.PCSource, if15.PCWriteCondEQ, if15.PCWriteCondNE, if15.instr_done}, 8'b00101011);
        $display("txn bne complete");

        // ori
        cyc(1'b0, 6'h0D, 1'b1);
        check("ori_c1_state", if15.state_o, 4'd0);
        cyc(1'b0, 6'h0D, 1'b1);
        check("ori_c2_state", if15.state_o, 4'd1);
        cyc(1'b0, 6'h0D, 1'b1);
        check("ori_c3_state", if15.state_o, 4'd10);
        check("ori_c3_alu", {if15.ALUOp, if15.ALUSrcA, if15.ALUSrcB, if15.RegWrite}, 7'b1011100);
        cyc(1'b0, 6'h0D, 1'b1);
        check("ori_c4_state", if15.state_o, 4'd11);
        check("ori_c4_wb", {if15.RegWrite, if15.RegDst, if15.instr_done}, 3'b101);
        $display("txn ori complete");

        // sw with memory never ready: timeout-4 instance halts after 4 MEM_WR cycles
        cyc(1'b0, 6'h2B, 1'b1);
        check("sw_c1_state", if4.state_o, 4'd0);
        cyc(1'b0, 6'h2B, 1'b1);
        check("sw_c2_state", if4.state_o, 4'd1);
        cyc(1'b0, 6'h2B, 1'b1);
        check("sw_c3_state", if4.state_o, 4'd2);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 6'h2B, 1'b0);
            check("sw_wait_state", if4.state_o, 4'd5);
            check("sw_wait_ctrl", {if4.MemWrite, if4.IorD, if4.instr_done, if4.bus_error}, 4'b1100);
        end
        cyc(1'b0, 6'h2B, 1'b0);
        check("to_halt_state", if4.state_o, 4'd12);
        check("to_bus_error", if4.bus_error, 1'b1);
        check("to_ctrl_zero", {if4.MemWrite, if4.MemRead, if4.IorD, if4.instr_done, if4.RegWrite}, 5'b00000);
        check("to15_still_wr", if15.state_o, 4'd5);
        cyc(1'b0, 6'h2B, 1'b0);
        check("to_halt_hold", {if4.state_o, if4.bus_error, if4.MemWrite, if4.PCWrite}, 7'b1100100);
        $display("txn sw timeout complete");

        // Reset while instance 15 is still in MEM_WR
        cyc(1'b1, 6'h00, 1'b1);
        check("rwr_state_pending", if15.state_o, 4'd5);
        check("rwr_memwrite_gated", if15.MemWrite, 1'b0);
        cyc(1'b0, 6'h00, 1'b1);
        check("rwr_state_after", if15.state_o, 4'd0);
        check("rwr_no_memwrite", if15.MemWrite, 1'b0);
        check("rwr_err_cleared", {if4.state_o, if4.bus_error}, 5'h00);
        $display("txn reset during sw complete");

        // R-type continues from this FETCH
        cyc(1'b0, 6'h00, 1'b1);
        check("r_c2_state", if15.state_o, 4'd1);
        cyc(1'b0, 6'h00, 1'b1);
        check("r_c3_state", if15.state_o, 4'd6);
        check("r_c3_alu", {if15.ALUOp, if15.ALUSrcA, if15.ALUSrcB}, 6'b111100);
        cyc(1'b0, 6'h00, 1'b1);
        check("r_c4_state", if15.state_o, 4'd7);
        check("r_c4_wb", {if15.RegDst, if15.RegWrite, if15.instr_done, if15.MemtoReg}, 4'b1110);
        $display("txn rtype complete");

        // j
        cyc(1'b0, 6'h02, 1'b1);
        check("j_c1_state", if15.state_o, 4'd0);
        cyc(1'b0, 6'h02, 1'b1);
        check("j_c2_state", if15.state_o, 4'd1);
        cyc(1'b0, 6'h02, 1'b1);
        check("j_c3_state", if15.state_o, 4'd9);
        check("j_c3_ctrl", {if15.PCWrite, if15.PCSource, if15.instr_done}, 4'b1101);
        $display("txn j complete");

        // Illegal opcode
        cyc(1'b0, 6'h3F, 1'b1);
        check("ill_c1_state", if15.state_o, 4'd0);
        cyc(1'b0, 6'h3F, 1'b1);
        check("ill_c2_state", if15.state_o, 4'd1);
        check("ill_c2_flag", if15.illegal_op, 1'b0);
        cyc(1'b0, 6'h3F, 1'b1);
        check("ill_halt_state", if15.state_o, 4'd12);
        check("ill_flags", {if15.illegal_op, if15.bus_error}, 2'b10);
        check("ill_ctrl_zero", {if15.MemRead, if15.IRWrite, if15.PCWrite, if15.instr_done}, 4'b0000);
        cyc(1'b0, 6'h00, 1'b1);
        check("ill_sticky", {if15.state_o, if15.illegal_op}, 5'b11001);
        $display("txn illegal complete");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle MIPS control FSM. It sequences a shared-memory datapath (PC, IR, register file, ALU, ALUOut/MDR registers) through fetch, decode, execute, memory and writeback, one instruction at a time. Memory accesses use a ready handshake with a timeout. Illegal opcodes and bus timeouts halt the core.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory state waits for mem_ready before bus error; 0 = wait forever.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
OP  in  6  opcode from IR[31:26]; stable from DECODE until the next FETCH completes
mem_ready  in  1  memory completes the current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCondEQ  out  1  PC load if ALU zero (beq)
PCWriteCondNE  out  1  PC load if ALU not zero (bne)
IorD  out  1  memory address: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR
IRWrite  out  1  IR load
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
ALUOp  out  3  ALU operation code (package constants)
ALUSrcA  out  1  0 = PC, 1 = rs register
ALUSrcB  out  2  00 = rt, 01 = constant 4, 10 = extended imm, 11 = imm<<2
RegWrite  out  1  register file write enable
RegDst  out  1  0 = rt, 1 = rd
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
illegal_op  out  1  sticky; unsupported opcode decoded
bus_error  out  1  sticky; memory timeout
state_o  out  4  current state, for debug

Behaviour:
- Reset: state <= FETCH; wait_cnt, illegal_op and bus_error <= 0. While reset is high, all control outputs and instr_done are forced to 0.
- Outputs are decoded from the state (Moore). The exceptions are IRWrite/PCWrite in FETCH, which are additionally qualified by mem_ready.
- Any output not listed for a state is 0.
- States and outputs:
- FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00. If mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Else stay.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=ADD. Next state by OP: 0x00 -> R_EXEC; 0x23/0x2B -> MEM_ADDR; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; 0x08/0x0C/0x0D/0x0F -> I_EXEC; other -> HALT with illegal_op set.
- MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Go to MEM_RD if OP=0x23, else MEM_WR.
- MEM_RD(3): MemRead=1, IorD=1. On mem_ready go to MEM_WB.
- MEM_WB(4): RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. Go to FETCH.
- MEM_WR(5): MemWrite=1, IorD=1. On mem_ready: instr_done=1, go to FETCH.
- R_EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=RTYPE. Go to R_WB.
- R_WB(7): RegDst=1, RegWrite=1, instr_done=1. Go to FETCH.
- BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01. PCWriteCondEQ=1 if OP=0x04; PCWriteCondNE=1 if OP=0x05. instr_done=1. Go to FETCH.
- JUMP(9): PCWrite=1, PCSource=10, instr_done=1. Go to FETCH.
- I_EXEC(10): ALUSrcA=1, ALUSrcB=10. ALUOp: ADDI for 0x08, ANDI for 0x0C, ORI for 0x0D, LUI for 0x0F. Go to I_WB.
- I_WB(11): RegDst=0, RegWrite=1, instr_done=1. Go to FETCH.
- HALT(12): all control outputs 0. Left only by reset.
- Latency with zero memory wait: R/I-type 4 cycles; lw 5; sw 4; beq/bne 3; j 3.
- Timeout counter: wait_cnt increments on each cycle spent in FETCH/MEM_RD/MEM_WR with mem_ready=0. It clears to 0 on any state change.
- If MEM_TIMEOUT != 0, mem_ready=0 and wait_cnt == MEM_TIMEOUT-1: go to HALT and set bus_error. At most MEM_TIMEOUT unready cycles are tolerated.
- mem_ready=1 in the timeout cycle wins: normal transition, no error.
- wait_cnt width is clog2(MEM_TIMEOUT+1), minimum 1. It saturates and never wraps.
- Reset mid-instruction (any state, including a pending memory access): the next cycle is FETCH. No partial writeback occurs after reset.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants: R_TYPE=0x00, J=0x02, BEQ=0x04, BNE=0x05, ADDI=0x08, ANDI=0x0C, ORI=0x0D, LUI=0x0F, LW=0x23, SW=0x2B;
  - ALUOp constants: ADD=000, SUB=001, LUI=011, ADDI=100, ORI=101, ANDI=110, RTYPE=111;
  - state encoding as a 4-bit enum.
- One sub-module, mem_wait_timer: wait_cnt plus the timeout compare, with inputs active/ready and output expired. Next-state and output decode stay in the top.

Test Plan:
- lw (OP=0x23), mem_ready always 1 -> states 0,1,2,3,4. MemtoReg=1 and RegWrite=1 only in cycle 5, where instr_done pulses. Back in FETCH on cycle 6.
- Fetch with mem_ready low for 3 cycles, then high -> MemRead=1 for 4 cycles; IRWrite and PCWrite high exactly once (cycle 4). No error with MEM_TIMEOUT=15.
- beq (0x04) then bne (0x05) -> 3 cycles each. In BRANCH: ALUOp=001, PCSource=01; CondEQ=1/CondNE=0 for beq, the reverse for bne.
- ori (0x0D) -> I_EXEC with ALUOp=101, ALUSrcB=10. I_WB with RegWrite=1, RegDst=0. 4 cycles total.
- MEM_TIMEOUT=4, sw with mem_ready held 0 -> 4 cycles in MEM_WR, then HALT. bus_error=1; all controls 0 until reset.
- OP=0x3F -> HALT after DECODE with illegal_op=1. Separately, reset asserted during MEM_WR -> no MemWrite the next cycle; state_o=0 after release.
